// File: rtl/sext_unit.sv
// Immediate generator: decodes the sign-extended immediate from an instruction word
// and presents it through a valid/ready stage with a 2-entry skid buffer.
module sext_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      sext_select,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic            imm_err
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic            err;
        logic [XLEN-1:0] imm;
    } entry_t;

    state_t      r_state;
    state_t      w_state_nxt;
    entry_t      r_main;
    entry_t      r_skid;
    entry_t      w_entry;
    logic [31:0] w_imm32;
    logic        w_err;
    logic        r_out_valid;
    logic        r_in_ready;
    logic        w_accept;
    logic        w_drain;
    logic        w_load_main;
    logic        w_load_skid;
    logic        w_main_from_skid;
    logic        w_unused;

    // Opcode field carries no immediate bits
    assign w_unused = ^instr[6:0];

    always_comb begin
        w_imm32 = '0;
        w_err   = 1'b0;
        case (sext_select)
            3'd0: w_imm32 = {{20{instr[31]}}, instr[31:20]};
            3'd1: w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            3'd2: w_imm32 = {instr[31:12], 12'b0};
            3'd3: w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'd4: w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: w_err = 1'b1;
        endcase
    end

    assign w_entry.err = w_err;
    assign w_entry.imm = XLEN'($signed(w_imm32));

    assign w_accept = in_valid && r_in_ready;
    assign w_drain  = r_out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != S_EMPTY);
            r_in_ready  <= (w_state_nxt != S_TWO);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = S_ONE;
                    w_load_main = 1'b1;
                end
            end
            S_ONE: begin
                if (w_accept && w_drain) begin
                    w_load_main = 1'b1;
                end else if (w_drain) begin
                    w_state_nxt = S_EMPTY;
                end else if (w_accept) begin
                    w_state_nxt = S_TWO;
                    w_load_skid = 1'b1;
                end
            end
            S_TWO: begin
                if (w_drain) begin
                    w_state_nxt      = S_ONE;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Main register feeds the outputs; skid only holds the overflow entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= w_entry;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_entry;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;
    assign imm       = r_main.imm;
    assign imm_err   = r_main.err;

endmodule

// File: tb/tb_sext_unit.sv
// Bench for sext_unit: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed immediates.
module tb_sext_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [2:0]  sext_select;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] imm;
    logic        imm_err;

    int checks;
    int failures;

    logic [32:0] model_q[$];

    sext_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .sext_select(sext_select),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .imm        (imm),
        .imm_err    (imm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference immediate built by weighting fields into position
    function automatic logic [32:0] ref_imm(input logic [31:0] x, input logic [2:0] s);
        logic [31:0] sgn;
        logic [31:0] r;
        logic        e;
        sgn = x[31] ? 32'hFFFF_FFFF : 32'h0;
        r   = 32'h0;
        e   = 1'b0;
        case (s)
            3'd0: r = (sgn << 11) | 32'(x[30:20]);
            3'd1: r = (sgn << 12) | (32'(x[7]) << 11) | (32'(x[30:25]) << 5) | (32'(x[11:8]) << 1);
            3'd2: r = x & 32'hFFFF_F000;
            3'd3: r = (sgn << 11) | (32'(x[30:25]) << 5) | 32'(x[11:7]);
            3'd4: r = (sgn << 20) | (32'(x[19:12]) << 12) | (32'(x[20]) << 11) | (32'(x[30:21]) << 1);
            default: e = 1'b1;
        endcase
        return {e, r};
    endfunction

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare against model at negedge, advance model at posedge
    task automatic cyc();
        logic        acc;
        logic        drn;
        logic [32:0] ent;
        @(negedge clk);
        chk("model_out_valid", 33'(out_valid), 33'(model_q.size() > 0));
        chk("model_in_ready", 33'(in_ready), 33'(model_q.size() < 2));
        if (model_q.size() > 0) begin
            chk("model_imm", {imm_err, imm}, model_q[0]);
        end
        acc = in_valid && (model_q.size() < 2);
        drn = out_ready && (model_q.size() > 0);
        ent = ref_imm(instr, sext_select);
        @(posedge clk);
        if (rst) begin
            model_q.delete();
        end else begin
            if (drn) void'(model_q.pop_front());
            if (acc) model_q.push_back(ent);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] x, input logic [2:0] s, input logic r);
        in_valid    = v;
        instr       = x;
        sext_select = s;
        out_ready   = r;
    endtask

    logic [31:0] stream_in[4]  = '{32'h0020A423, 32'hFE000EE3, 32'h123450B7, 32'h0010006F};
    logic [2:0]  stream_sel[4] = '{3'd3, 3'd1, 3'd2, 3'd4};
    logic [31:0] stream_exp[4] = '{32'h00000008, 32'hFFFFFFFC, 32'h12345000, 32'h00000800};

    initial begin
        logic [31:0] rx;
        logic [2:0]  rs;
        logic [32:0] prev;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(1'b0, 32'h0, 3'd0, 1'b0);
        cyc();
        cyc();
        chk("rst_out_valid", 33'(out_valid), 33'(0));
        chk("rst_imm", 33'(imm), 33'(0));
        chk("rst_imm_err", 33'(imm_err), 33'(0));
        chk("rst_in_ready", 33'(in_ready), 33'(1));
        rst = 1'b0;
        cyc();

        // Single I-format pulse
        drive(1'b1, 32'hFFF00093, 3'd0, 1'b1);
        cyc();
        chk("single_valid", 33'(out_valid), 33'(1));
        chk("single_imm", 33'(imm), 33'(32'hFFFFFFFF));
        chk("single_err", 33'(imm_err), 33'(0));
        drive(1'b0, 32'h0, 3'd0, 1'b1);
        cyc();
        chk("single_after_valid", 33'(out_valid), 33'(0));

        // Back-to-back streaming
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, stream_in[k], stream_sel[k], 1'b1);
            cyc();
            chk("stream_valid", 33'(out_valid), 33'(1));
            chk("stream_imm", 33'(imm), 33'(stream_exp[k]));
            chk("stream_in_ready", 33'(in_ready), 33'(1));
        end
        drive(1'b0, 32'h0, 3'd0, 1'b1);
        cyc();

        // Backpressure: three entries offered, downstream stalled
        drive(1'b1, 32'h00100013, 3'd0, 1'b0);
        cyc();
        drive(1'b1, 32'h00200013, 3'd0, 1'b0);
        cyc();
        chk("bp_in_ready_low", 33'(in_ready), 33'(0));
        drive(1'b1, 32'h00300013, 3'd0, 1'b0);
        cyc();
        cyc();
        chk("bp_hold_imm", 33'(imm), 33'(1));
        chk("bp_hold_ready", 33'(in_ready), 33'(0));
        out_ready = 1'b1;
        cyc();
        chk("bp_second", 33'(imm), 33'(2));
        chk("bp_second_valid", 33'(out_valid), 33'(1));
        cyc();
        chk("bp_third", 33'(imm), 33'(3));
        drive(1'b0, 32'h0, 3'd0, 1'b1);
        cyc();
        chk("bp_drained", 33'(out_valid), 33'(0));

        // Illegal format then legal with same word
        drive(1'b1, 32'hFFFFFFFF, 3'd6, 1'b1);
        cyc();
        chk("illegal_imm", 33'(imm), 33'(0));
        chk("illegal_err", 33'(imm_err), 33'(1));
        drive(1'b1, 32'hFFFFFFFF, 3'd0, 1'b1);
        cyc();
        chk("legal_imm", 33'(imm), 33'(32'hFFFFFFFF));
        chk("legal_err", 33'(imm_err), 33'(0));
        drive(1'b0, 32'h0, 3'd0, 1'b1);
        cyc();

        // Asynchronous reset with both entries buffered
        drive(1'b1, 32'h00500013, 3'd0, 1'b0);
        cyc();
        drive(1'b1, 32'h00600013, 3'd0, 1'b0);
        cyc();
        chk("pre_rst_in_ready", 33'(in_ready), 33'(0));
        drive(1'b0, 32'h0, 3'd0, 1'b0);
        #2;
        rst = 1'b1;
        model_q.delete();
        #1;
        chk("arst_out_valid", 33'(out_valid), 33'(0));
        chk("arst_imm", 33'(imm), 33'(0));
        chk("arst_in_ready", 33'(in_ready), 33'(1));
        cyc();
        rst = 1'b0;
        drive(1'b1, 32'h00700013, 3'd0, 1'b1);
        cyc();
        chk("post_rst_first", 33'(imm), 33'(7));
        chk("post_rst_valid", 33'(out_valid), 33'(1));

        // Simultaneous accept and drain with random words
        prev = ref_imm(32'h00700013, 3'd0);
        for (int k = 0; k < 10; k++) begin
            rx = $urandom;
            rs = 3'($urandom_range(0, 4));
            drive(1'b1, rx, rs, 1'b1);
            chk("ad_prev_imm", {imm_err, imm}, prev);
            cyc();
            chk("ad_in_ready", 33'(in_ready), 33'(1));
            chk("ad_out_valid", 33'(out_valid), 33'(1));
            prev = ref_imm(rx, rs);
        end
        chk("ad_last_imm", {imm_err, imm}, prev);
        drive(1'b0, 32'h0, 3'd0, 1'b1);
        cyc();
        cyc();

        // Pin the reference model against literals
        chk("ref_I", ref_imm(32'hFFF00093, 3'd0), {1'b0, 32'hFFFFFFFF});
        chk("ref_S", ref_imm(32'h0020A423, 3'd3), {1'b0, 32'h00000008});
        chk("ref_B", ref_imm(32'hFE000EE3, 3'd1), {1'b0, 32'hFFFFFFFC});
        chk("ref_J", ref_imm(32'h0010006F, 3'd4), {1'b0, 32'h00000800});
        chk("ref_bad", ref_imm(32'hFFFFFFFF, 3'd7), {1'b1, 32'h00000000});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
